// File: rtl/project_select_ctrl.sv
// Wishbone-controlled sequencer for the per-project active lines: drain, guard, reset, release.
// Optional Logic Analyzer request path is enabled by defining PROJECT_SELECT_LA_EN.
module project_select_ctrl #(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned RESET_CYCLES = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [7:0]              la_sel_i,
    input  logic                    la_en_i,
    input  logic                    la_req_i,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic [NUM_PROJECTS-1:0] proj_rst_o,
    output logic                    busy_o,
    output logic                    irq_o
);

    localparam int unsigned MaxCnt = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [1:0] {StSteady, StDrain, StReset} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          cur_id_q, cur_id_d, pend_id_q, pend_id_d;
    logic                cur_en_q, cur_en_d, pend_en_q, pend_en_d;
    logic                err_q, err_d, irq_q, irq_d, ack_q, ack_d;
    logic [31:0]         dat_q, dat_d, rdata;
    logic                wb_acc, wb_wr, la_rise, req_valid, req_en, req_bad, differ;
    logic [7:0]          req_id;
    logic [1:0]          reg_off;
    logic [NUM_PROJECTS-1:0] onehot;

    assign reg_off = wbs_adr_i[3:2];
    // One access per strobe: the cycle carrying the ack never starts another access.
    assign wb_acc  = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_wr   = wb_acc & wbs_we_i;

`ifdef PROJECT_SELECT_LA_EN
    logic la_req_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) la_req_q <= 1'b0;
        else            la_req_q <= la_req_i;
    end
    assign la_rise = la_req_i & ~la_req_q;
`else
    logic unused_la;
    assign unused_la = la_req_i;
    assign la_rise   = 1'b0;
`endif

    logic unused_wb;
    assign unused_wb = ^{wbs_sel_i[3:2], wbs_dat_i[31:9], wbs_adr_i[1:0]};

    always_comb begin
        req_valid = 1'b0;
        req_id    = 8'h00;
        req_en    = 1'b0;
        if (wb_wr && reg_off == 2'd0 && wbs_sel_i[1:0] == 2'b11) begin
            req_valid = 1'b1;
            req_id    = wbs_dat_i[7:0];
            req_en    = wbs_dat_i[8];
        end else if (la_rise && !wb_wr) begin
            req_valid = 1'b1;
            req_id    = la_sel_i;
            req_en    = la_en_i;
        end
    end

    assign req_bad = req_valid & req_en & (32'(req_id) >= NUM_PROJECTS);

    always_comb begin
        unique case (reg_off)
            2'd0:    rdata = {23'd0, pend_en_q, pend_id_q};
            2'd1:    rdata = {8'd0, pend_id_q, 5'd0, err_q, busy_o, cur_en_q, cur_id_q};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        pend_id_d = pend_id_q;
        pend_en_d = pend_en_q;
        err_d     = err_q;
        ack_d     = wb_acc;
        dat_d     = (wb_acc && !wbs_we_i) ? rdata : 32'd0;
        if (wb_acc && !wbs_we_i && reg_off == 2'd1) err_d = 1'b0;
        if (req_bad) begin
            err_d = 1'b1;
        end else if (req_valid) begin
            pend_id_d = req_id;
            pend_en_d = req_en;
        end
    end

    // A disabled request matches a disabled current selection regardless of ids.
    assign differ = (pend_en_q != cur_en_q) || (pend_en_q && (pend_id_q != cur_id_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_id_d = cur_id_q;
        cur_en_d = cur_en_q;
        irq_d    = 1'b0;
        unique case (state_q)
            StSteady: begin
                if (differ) begin
                    state_d = StDrain;
                    cnt_d   = CntW'(GUARD_CYCLES - 1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    cur_id_d = pend_id_q;
                    cur_en_d = pend_en_q;
                    if (pend_en_q) begin
                        state_d = StReset;
                        cnt_d   = CntW'(RESET_CYCLES - 1);
                    end else begin
                        state_d = StSteady;
                        irq_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StReset: begin
                if (cnt_q == '0) begin
                    state_d = StSteady;
                    irq_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StSteady;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StSteady;
            cnt_q     <= '0;
            cur_id_q  <= 8'h00;
            cur_en_q  <= 1'b0;
            pend_id_q <= 8'h00;
            pend_en_q <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_id_q  <= cur_id_d;
            cur_en_q  <= cur_en_d;
            pend_id_q <= pend_id_d;
            pend_en_q <= pend_en_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(NUM_PROJECTS); i++) begin
            if (cur_id_q == 8'(i)) onehot[i] = 1'b1;
        end
    end

    always_comb begin
        active_o   = '0;
        proj_rst_o = '0;
        if ((state_q == StSteady && cur_en_q) || state_q == StReset) active_o = onehot;
        if (state_q == StReset) proj_rst_o = onehot;
    end

    assign busy_o    = (state_q != StSteady);
    assign irq_o     = irq_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule
